linear_layer_srl_fifo_af: RTL

Parametrised shift-register FIFO used between HLS dataflow processes in the Linear_Layer accelerator (PE start tokens, packed i4xi4 operand streams). It extends the plain addressable SRL cell with several additions:
- write/read handshakes with clock-enable gating;
- registered full/empty flags;
- a programmable almost-full flag;
- an occupancy count, for producers that must stop issuing early.

An optional output register stage is available for timing closure on wide data.

---
 rtl/linear_layer_srl_fifo_af.sv | 115 +++++++++++
 1 files changed

// File: rtl/linear_layer_srl_fifo_af.sv
// Shift-register FIFO with registered full/empty/almost-full flags and an occupancy count.
// Define LINEAR_LAYER_SRL_FIFO_OUTREG_EN to add a registered head stage (capacity DEPTH+1).
module linear_layer_srl_fifo_af #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   output logic                  if_almost_full,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

`ifdef LINEAR_LAYER_SRL_FIFO_OUTREG_EN
   localparam int CAPACITY = DEPTH + 1;
`else
   localparam int CAPACITY = DEPTH;
`endif
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
   localparam logic [CW-1:0] AF_C  = CW'(CAPACITY - AFULL_MARGIN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic                  full_n;
   logic                  empty_n;
   logic                  almost_full;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_acc = if_write & if_write_ce & full_n;
   assign rd_acc = if_read & if_read_ce & empty_n;

   // SRL storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[0] <= if_din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         full_n      <= 1'b1;
         almost_full <= 1'b0;
      end else begin
         count       <= count_nxt;
         full_n      <= (count_nxt != CAP_C);
         almost_full <= (count_nxt >= AF_C);
      end
   end

`ifdef LINEAR_LAYER_SRL_FIFO_OUTREG_EN
   logic [CW-1:0]         srl_cnt;
   logic [ADDR_WIDTH-1:0] srl_addr;
   logic                  load;
   logic                  valid;
   logic [DATA_WIDTH-1:0] dout_reg;

   // The stage refills from the oldest SRL entry whenever it empties or is being read.
   assign srl_addr = ADDR_WIDTH'(srl_cnt - CW'(1));
   assign load     = (!valid || rd_acc) && (srl_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         srl_cnt  <= '0;
         valid    <= 1'b0;
         dout_reg <= '0;
      end else begin
         if (load) dout_reg <= mem[srl_addr];
         if (load)        valid <= 1'b1;
         else if (rd_acc) valid <= 1'b0;
         if (wr_acc && !load)      srl_cnt <= srl_cnt + CW'(1);
         else if (load && !wr_acc) srl_cnt <= srl_cnt - CW'(1);
      end
   end

   assign empty_n = valid;
   assign if_dout = dout_reg;
`else
   logic [ADDR_WIDTH-1:0] head_addr;

   assign head_addr = ADDR_WIDTH'(count - CW'(1));

   always_ff @(posedge clk) begin
      if (reset) empty_n <= 1'b0;
      else       empty_n <= (count_nxt != '0);
   end

   assign if_dout = mem[head_addr];
`endif

   assign if_full_n         = full_n;
   assign if_empty_n        = empty_n;
   assign if_almost_full    = almost_full;
   assign if_num_data_valid = count;

endmodule
